axi4lite_arbiter: RTL
=====================

// Module: axi4lite_arbiter
//
// PURPOSE
//  Two-master to one-slave AXI4-Lite arbiter/scheduler. It shares a single AXI4-Lite slave port
//  between masters 0 and 1 and allows exactly one transaction (write or read) in flight at a time.
//  Masters with a pending request are granted in round-robin order.
//  Sits between two bus masters (e.g. CPU and DMA) and one axi4lite slave. Field widths come from axi4lite_pkg.
//
// PARAMETERS
//  ADDRWIDTH  32  address width (matches axi4lite_pkg)
//  DATAWIDTH  32  data width (matches axi4lite_pkg)
//
// PORTS  (M_* are [1:0] vectors/arrays indexed by master; S_* face the slave)
//  ACLK                     in   1              system clock; all logic rising-edge
//  ARESETN                  in   1              synchronous, active-low reset
//  M_AWADDR, M_AWVALID      in   2x[ADDRWIDTH],2  write address and valid, per master
//  M_AWREADY                out  2              write address ready, per master
//  M_WDATA, M_WVALID        in   2x[DATAWIDTH],2  write data and valid, per master
//  M_WREADY                 out  2              write data ready, per master
//  M_BVALID                 out  2              write response valid, per master
//  M_BREADY                 in   2              write response ready, per master
//  M_ARADDR, M_ARVALID      in   2x[ADDRWIDTH],2  read address and valid, per master
//  M_ARREADY                out  2              read address ready, per master
//  M_RDATA, M_RVALID        out  2x[DATAWIDTH],2  read data and valid, per master
//  M_RREADY                 in   2              read data ready, per master
//  S_AWADDR,S_AWVALID / S_WDATA,S_WVALID / S_BREADY      out  slave write side
//  S_AWREADY / S_WREADY / S_BVALID                       in   slave write side
//  S_ARADDR,S_ARVALID / S_RREADY                         out  slave read side
//  S_ARREADY / S_RDATA,S_RVALID                          in   slave read side
//  GRANT                    out  2              one-hot owner of the slave; 00 when idle
//  BUSY                     out  1              1 whenever state != IDLE
//
// BEHAVIOUR
//  - FSM states: IDLE, WADDR, WRESP, RADDR, RDATA. Registers: state, g (granted master),
//    last (previous owner), aw_done, w_done.
//  - Reset (ARESETN==0 at clock edge):
//    - state=IDLE, last=1 (so master 0 wins first), aw_done=w_done=0.
//    - Every output is 0, including addr/data buses. Reset mid-transaction abandons the transfer.
//  - Request from master i: req[i] = M_AWVALID[i] | M_ARVALID[i]. If a master asserts both, write is served first.
//  - IDLE arbitration:
//    - If both masters request, grant ~last. If one requests, grant it.
//    - g is registered; the next state is WADDR or RADDR.
//    - Nothing reaches the slave in the arbitration cycle (1-cycle grant latency).
//  - Routing: only master g is connected. Non-granted masters see READY/VALID=0 and M_RDATA=0.
//    All slave-facing valid/ready signals are 0 in IDLE. Muxing is combinational from g and state.
//  - WADDR:
//    - S_AWADDR=M_AWADDR[g]; S_AWVALID=M_AWVALID[g]&~aw_done; M_AWREADY[g]=S_AWREADY&~aw_done.
//    - The W channel is handled the same way using w_done.
//    - AW and W handshakes may complete in any order or in the same cycle.
//    - Each sets its *_done flag. When both are done, go to WRESP and clear the flags.
//  - WRESP: M_BVALID[g]=S_BVALID; S_BREADY=M_BREADY[g]. On handshake -> IDLE, last=g.
//  - RADDR: S_ARADDR/S_ARVALID from master g; M_ARREADY[g]=S_ARREADY. On handshake -> RDATA.
//  - RDATA: M_RDATA[g]=S_RDATA; M_RVALID[g]=S_RVALID; S_RREADY=M_RREADY[g]. On handshake -> IDLE, last=g.
//  - Minimum cost per transaction: 3 cycles (IDLE + address + response), with back-to-back ready.
//  - A request arriving while BUSY waits; there is no pre-emption or timeout.
//  - VALID stability is the master's AXI obligation. A VALID dropped before its handshake is not recovered.
//  - GRANT=onehot(g) in all non-IDLE states.
//
// TESTING
//  1. Hold ARESETN=0 for 2 cycles with M_AWVALID[0]=1 -> all outputs 0 and GRANT=00.
//     The cycle after release, GRANT=01.
//  2. M0 writes 0x10/0xDEADBEEF, slave always ready -> S_AWADDR=0x10, S_WDATA=0xDEADBEEF.
//     M_BVALID[0] pulses, M_BVALID[1]=0, then GRANT=00.
//  3. Same cycle: M0 writes, M1 reads 0x20 -> M0 is served first. Slave returns 0x12345678
//     -> it appears only on M_RDATA[1]/M_RVALID[1].
//  4. Both masters issue reads continuously -> GRANT sequence is 01,10,01,10 over 4 transactions.
//  5. Slave raises AWREADY at cycle 1 and WREADY at cycle 3 -> S_AWVALID=0 from cycle 2, S_WVALID is held
//     through cycle 3, then WRESP.
//  6. ARESETN=0 during WRESP with S_BVALID=1 -> next cycle all outputs 0 and state IDLE.
//     After release, a simultaneous request from both masters is granted to M0.

Source files
------------

// File: rtl/axi4lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: one transaction in flight, round-robin grant.
// All routing is combinational from the registered owner and FSM state.
module axi4lite_arbiter #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [1:0][ADDRWIDTH-1:0]       M_AWADDR,
    input  logic [1:0]                      M_AWVALID,
    output logic [1:0]                      M_AWREADY,
    input  logic [1:0][DATAWIDTH-1:0]       M_WDATA,
    input  logic [1:0]                      M_WVALID,
    output logic [1:0]                      M_WREADY,
    output logic [1:0]                      M_BVALID,
    input  logic [1:0]                      M_BREADY,
    input  logic [1:0][ADDRWIDTH-1:0]       M_ARADDR,
    input  logic [1:0]                      M_ARVALID,
    output logic [1:0]                      M_ARREADY,
    output logic [1:0][DATAWIDTH-1:0]       M_RDATA,
    output logic [1:0]                      M_RVALID,
    input  logic [1:0]                      M_RREADY,
    output logic [ADDRWIDTH-1:0]            S_AWADDR,
    output logic                            S_AWVALID,
    input  logic                            S_AWREADY,
    output logic [DATAWIDTH-1:0]            S_WDATA,
    output logic                            S_WVALID,
    input  logic                            S_WREADY,
    input  logic                            S_BVALID,
    output logic                            S_BREADY,
    output logic [ADDRWIDTH-1:0]            S_ARADDR,
    output logic                            S_ARVALID,
    input  logic                            S_ARREADY,
    input  logic [DATAWIDTH-1:0]            S_RDATA,
    input  logic                            S_RVALID,
    output logic                            S_RREADY,
    output logic [1:0]                      GRANT,
    output logic                            BUSY,
    output logic [2:0]                      DBG_STATE
);

    // Every channel uses standard AXI valid/ready: a transfer happens in the
    // cycle where both VALID and READY are high at the rising edge.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_g, w_g_nxt;
    logic       r_last, w_last_nxt;
    logic       r_aw_done, w_aw_done_nxt;
    logic       r_w_done, w_w_done_nxt;

    logic [1:0] w_req;
    logic       w_pick;
    logic       w_aw_hs;
    logic       w_w_hs;

    assign w_req   = M_AWVALID | M_ARVALID;
    // With both requesting, the master that did not own the slave last wins.
    assign w_pick  = (&w_req) ? ~r_last : w_req[1];
    assign w_aw_hs = (r_state == WADDR) & M_AWVALID[r_g] & S_AWREADY & ~r_aw_done;
    assign w_w_hs  = (r_state == WADDR) & M_WVALID[r_g] & S_WREADY & ~r_w_done;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state   <= IDLE;
            r_g       <= 1'b0;
            r_last    <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_g       <= w_g_nxt;
            r_last    <= w_last_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_g_nxt       = r_g;
        w_last_nxt    = r_last;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_g_nxt     = w_pick;
                    w_state_nxt = M_AWVALID[w_pick] ? WADDR : RADDR;
                end
            end
            WADDR: begin
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
                    w_state_nxt   = WRESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else begin
                    w_aw_done_nxt = r_aw_done | w_aw_hs;
                    w_w_done_nxt  = r_w_done | w_w_hs;
                end
            end
            WRESP: begin
                if (S_BVALID && M_BREADY[r_g]) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_g;
                end
            end
            RADDR: begin
                if (M_ARVALID[r_g] && S_ARREADY) begin
                    w_state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (S_RVALID && M_RREADY[r_g]) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_g;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        M_AWREADY = '0;
        M_WREADY  = '0;
        M_BVALID  = '0;
        M_ARREADY = '0;
        M_RDATA   = '0;
        M_RVALID  = '0;
        S_AWADDR  = '0;
        S_AWVALID = 1'b0;
        S_WDATA   = '0;
        S_WVALID  = 1'b0;
        S_BREADY  = 1'b0;
        S_ARADDR  = '0;
        S_ARVALID = 1'b0;
        S_RREADY  = 1'b0;
        GRANT     = '0;
        case (r_state)
            WADDR: begin
                S_AWADDR       = M_AWADDR[r_g];
                S_AWVALID      = M_AWVALID[r_g] & ~r_aw_done;
                M_AWREADY[r_g] = S_AWREADY & ~r_aw_done;
                S_WDATA        = M_WDATA[r_g];
                S_WVALID       = M_WVALID[r_g] & ~r_w_done;
                M_WREADY[r_g]  = S_WREADY & ~r_w_done;
            end
            WRESP: begin
                M_BVALID[r_g] = S_BVALID;
                S_BREADY      = M_BREADY[r_g];
            end
            RADDR: begin
                S_ARADDR       = M_ARADDR[r_g];
                S_ARVALID      = M_ARVALID[r_g];
                M_ARREADY[r_g] = S_ARREADY;
            end
            RDATA: begin
                M_RDATA[r_g]  = S_RDATA;
                M_RVALID[r_g] = S_RVALID;
                S_RREADY      = M_RREADY[r_g];
            end
            default: ;
        endcase
        if (r_state != IDLE) begin
            GRANT[r_g] = 1'b1;
        end
    end

    assign BUSY      = (r_state != IDLE);
    assign DBG_STATE = r_state;

endmodule
